// File: rtl/sophon_pkg.sv
// Shared LSU request/ack payloads and atomic-op encodings for the TCM responder.
package sophon_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned STRBW = XLEN / 8;
  localparam int unsigned AMOW  = 4;

  localparam logic [AMOW-1:0] AMO_NONE = 4'd0;
  localparam logic [AMOW-1:0] AMO_SWAP = 4'd1;
  localparam logic [AMOW-1:0] AMO_ADD  = 4'd2;
  localparam logic [AMOW-1:0] AMO_XOR  = 4'd3;
  localparam logic [AMOW-1:0] AMO_AND  = 4'd4;
  localparam logic [AMOW-1:0] AMO_OR   = 4'd5;
  localparam logic [AMOW-1:0] AMO_MIN  = 4'd6;
  localparam logic [AMOW-1:0] AMO_MAX  = 4'd7;
  localparam logic [AMOW-1:0] AMO_MINU = 4'd8;
  localparam logic [AMOW-1:0] AMO_MAXU = 4'd9;

  typedef struct packed {
    logic             req;
    logic             we;
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  wdata;
    logic [AMOW-1:0]  amo;
    logic [1:0]       size;
    logic [STRBW-1:0] strb;
  } lsu_req_t;

  typedef struct packed {
    logic            ack;
    logic            error;
    logic [XLEN-1:0] rdata;
  } lsu_ack_t;

  // Read-modify-write result for a defined atomic code; undefined codes keep the old word.
  function automatic logic [XLEN-1:0] amo_apply(input logic [AMOW-1:0] code,
                                                input logic [XLEN-1:0] old,
                                                input logic [XLEN-1:0] opnd);
    logic [XLEN-1:0] res;
    res = old;
    case (code)
      AMO_SWAP: res = opnd;
      AMO_ADD:  res = old + opnd;
      AMO_XOR:  res = old ^ opnd;
      AMO_AND:  res = old & opnd;
      AMO_OR:   res = old | opnd;
      AMO_MIN:  res = ($signed(old) < $signed(opnd)) ? old : opnd;
      AMO_MAX:  res = ($signed(old) > $signed(opnd)) ? old : opnd;
      AMO_MINU: res = (old < opnd) ? old : opnd;
      AMO_MAXU: res = (old > opnd) ? old : opnd;
      default:  res = old;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/tcm_sram.sv
// Single-port word SRAM: 1-cycle registered read, per-byte write enable, no reset.
module tcm_sram
  import sophon_pkg::*;
#(
  parameter int unsigned WORDS = 16384,
  parameter int unsigned IW    = 14
) (
  input  logic             clk_i,
  input  logic             en,
  input  logic             we,
  input  logic [STRBW-1:0] be,
  input  logic [IW-1:0]    idx,
  input  logic [XLEN-1:0]  wdata,
  output logic [XLEN-1:0]  rdata
);

  logic [XLEN-1:0] mem [WORDS];

  // Read data holds its last value across writes and idle cycles.
  always_ff @(posedge clk_i) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < int'(STRBW); b++) begin
          if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/lsu_tcm_responder.sv
// LSU slave for the data TCM: loads, byte-masked stores and 2-cycle atomic read-modify-writes.
module lsu_tcm_responder
  import sophon_pkg::*;
#(
  parameter logic [31:0] BASE = 32'h8009_0000,
  parameter logic [31:0] SIZE = 32'h0001_0000
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  lsu_req_t lsu_req_i,
  output lsu_ack_t lsu_ack_o
);

  localparam int unsigned AW    = $clog2(SIZE);
  localparam int unsigned IW    = (AW > 2) ? AW - 2 : 1;
  localparam int unsigned WORDS = SIZE >> 2;

  typedef enum logic [1:0] {IDLE, RESP, AMO_RD, AMO_WR} state_t;

  state_t          state, state_next;
  logic            err_flag, load_flag;
  logic [AMOW-1:0] amo_op;
  logic [XLEN-1:0] amo_opnd, old_word;
  logic [IW-1:0]   amo_idx;

  logic [XLEN-1:0] offset;
  logic [IW-1:0]   req_idx;
  logic            in_range, misaligned, bad_amo, req_err, accept;

  logic             mem_en, mem_we;
  logic [STRBW-1:0] mem_be;
  logic [IW-1:0]    mem_idx;
  logic [XLEN-1:0]  mem_wdata, mem_rdata;

  // Request decode: range, alignment and atomic legality.
  always_comb begin
    offset     = lsu_req_i.addr - BASE;
    req_idx    = IW'(offset >> 2);
    in_range   = (lsu_req_i.addr >= BASE) && (offset < SIZE);
    misaligned = ((lsu_req_i.size == 2'd1) && lsu_req_i.addr[0]) ||
                 ((lsu_req_i.size == 2'd2) && (lsu_req_i.addr[1:0] != 2'b00));
    bad_amo    = (lsu_req_i.amo > AMO_MAXU) ||
                 ((lsu_req_i.amo != AMO_NONE) && (lsu_req_i.size != 2'd2));
    req_err    = !in_range || (lsu_req_i.size == 2'd3) || misaligned || bad_amo;
  end

  // Next state and SRAM port control.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_be     = '0;
    mem_idx    = req_idx;
    mem_wdata  = lsu_req_i.wdata;
    case (state)
      IDLE: begin
        if (lsu_req_i.req) begin
          accept = 1'b1;
          if (req_err) begin
            state_next = RESP;
          end else if (lsu_req_i.amo != AMO_NONE) begin
            mem_en     = 1'b1;
            state_next = AMO_RD;
          end else begin
            mem_en     = 1'b1;
            mem_we     = lsu_req_i.we;
            mem_be     = lsu_req_i.strb;
            state_next = RESP;
          end
        end
      end
      RESP: state_next = IDLE;
      AMO_RD: begin
        mem_en     = 1'b1;
        mem_we     = 1'b1;
        mem_be     = '1;
        mem_idx    = amo_idx;
        mem_wdata  = amo_apply(amo_op, mem_rdata, amo_opnd);
        state_next = AMO_WR;
      end
      AMO_WR: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      err_flag  <= 1'b0;
      load_flag <= 1'b0;
      amo_op    <= AMO_NONE;
      amo_opnd  <= '0;
      amo_idx   <= '0;
      old_word  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        err_flag  <= req_err;
        load_flag <= !req_err && !lsu_req_i.we && (lsu_req_i.amo == AMO_NONE);
        amo_op    <= lsu_req_i.amo;
        amo_opnd  <= lsu_req_i.wdata;
        amo_idx   <= req_idx;
      end
      if (state == AMO_RD) old_word <= mem_rdata;
    end
  end

  // Ack and data decode straight from the state flop and the SRAM output register.
  always_comb begin
    lsu_ack_o       = '0;
    lsu_ack_o.ack   = (state == RESP) || (state == AMO_WR);
    lsu_ack_o.error = (state == RESP) && err_flag;
    if ((state == RESP) && load_flag) lsu_ack_o.rdata = mem_rdata;
    else if (state == AMO_WR)         lsu_ack_o.rdata = old_word;
  end

  tcm_sram #(
    .WORDS (WORDS),
    .IW    (IW)
  ) u_sram (
    .clk_i (clk_i),
    .en    (mem_en),
    .we    (mem_we),
    .be    (mem_be),
    .idx   (mem_idx),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_lsu_tcm_responder.sv
// Scoreboard bench for lsu_tcm_responder: directed cases then randomized traffic vs a word-array model.
module tb_lsu_tcm_responder;
  import sophon_pkg::*;

  localparam logic [31:0] BASE = 32'h8009_0000;
  localparam logic [31:0] SIZE = 32'h0001_0000;

  logic     clk = 1'b0;
  logic     rst;
  lsu_req_t req;
  lsu_ack_t ack;

  always #5 clk = ~clk;

  lsu_tcm_responder #(.BASE(BASE), .SIZE(SIZE)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .lsu_req_i (req),
    .lsu_ack_o (ack)
  );

  typedef struct {
    logic        error;
    logic [31:0] rdata;
    string       name;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl[int];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ack pops one expected response.
  always @(negedge clk) begin
    if (rst === 1'b0 && ack.ack === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack: got rdata %h error %b with empty scoreboard", ack.rdata, ack.error);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_error"}, 32'(ack.error), 32'(e.error));
        check({e.name, "_rdata"}, ack.rdata, e.rdata);
      end
    end
  end

  // Reference model: whole-word memory plus the access rules, updated on each accepted request.
  function automatic void model(input lsu_req_t r, output logic err, output logic [31:0] rd,
                                output int lat);
    longint      a, lo, hi;
    int          bytes, w;
    logic [31:0] old, nw;
    a     = longint'(r.addr);
    lo    = longint'(BASE);
    hi    = lo + longint'(SIZE);
    bytes = 1 << r.size;
    err   = (a < lo) || (a >= hi) || (r.size == 2'd3) || ((a % bytes) != 0) ||
            (r.amo > 4'd9) || (r.amo != 4'd0 && r.size != 2'd2);
    rd  = 32'h0;
    lat = 1;
    if (err) return;
    w   = int'((a - lo) / 4);
    old = mdl.exists(w) ? mdl[w] : 32'hx;
    if (r.amo == 4'd0) begin
      if (r.we) begin
        nw = old;
        for (int b = 0; b < 4; b++) if (r.strb[b]) nw[8*b +: 8] = r.wdata[8*b +: 8];
        mdl[w] = nw;
      end else begin
        rd = old;
      end
    end else begin
      case (r.amo)
        4'd1: nw = r.wdata;
        4'd2: nw = 32'(longint'(old) + longint'(r.wdata));
        4'd3: nw = old ^ r.wdata;
        4'd4: nw = old & r.wdata;
        4'd5: nw = old | r.wdata;
        4'd6: nw = (int'(old) < int'(r.wdata)) ? old : r.wdata;
        4'd7: nw = (int'(old) > int'(r.wdata)) ? old : r.wdata;
        4'd8: nw = (longint'(old) < longint'(r.wdata)) ? old : r.wdata;
        default: nw = (longint'(old) > longint'(r.wdata)) ? old : r.wdata;
      endcase
      mdl[w] = nw;
      rd     = old;
      lat    = 2;
    end
  endfunction

  function automatic lsu_req_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [3:0] amo, input logic [1:0] size, input logic [3:0] strb);
    lsu_req_t r;
    r.req   = 1'b1;
    r.we    = we;
    r.addr  = addr;
    r.wdata = wdata;
    r.amo   = amo;
    r.size  = size;
    r.strb  = strb;
    return r;
  endfunction

  // Drive one request (called just after a rising edge), wait for its ack, check latency.
  task automatic xact(input lsu_req_t r, input string name, output int ack_cyc);
    logic e;
    logic [31:0] rd;
    int lat, n;
    model(r, e, rd, lat);
    sb.push_back('{e, rd, name});
    req = r;
    n = 0;
    forever begin
      @(negedge clk);
      if (ack.ack === 1'b1) break;
      n++;
      if (n > 12) break;
    end
    if (n > 12) $display("FAIL %s_timeout: no ack within 12 cycles", name);
    check({name, "_latency"}, 32'(n), 32'(lat));
    ack_cyc = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req.req = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int t, c0, c1, c2, c3;
    lsu_req_t r;
    rst = 1'b1;
    req = '0;
    #2;
    check("reset_ack", 32'(ack.ack), 32'h0);
    check("reset_error", 32'(ack.error), 32'h0);
    check("reset_rdata", ack.rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    // Preload every word the random traffic can reach.
    for (int i = 0; i < 16; i++) xact(mk(1'b1, BASE + 32'(4 * i), $urandom, 4'd0, 2'd2, 4'hF), "init", t);
    xact(mk(1'b1, BASE + SIZE - 32'd4, $urandom, 4'd0, 2'd2, 4'hF), "init_top", t);

    xact(mk(1'b1, 32'h8009_0010, 32'hDEAD_BEEF, 4'd0, 2'd2, 4'hF), "word_wr", t);
    xact(mk(1'b0, 32'h8009_0010, 32'h0, 4'd0, 2'd2, 4'hF), "word_rd", t);
    xact(mk(1'b1, 32'h8009_0011, 32'h0000_AB00, 4'd0, 2'd0, 4'b0010), "byte_wr", t);
    xact(mk(1'b0, 32'h8009_0010, 32'h0, 4'd0, 2'd2, 4'hF), "byte_rd", t);
    xact(mk(1'b1, 32'h8009_0010, 32'h1111_1111, 4'd0, 2'd2, 4'h0), "strb0_wr", t);
    xact(mk(1'b0, 32'h8009_0010, 32'h0, 4'd0, 2'd2, 4'hF), "strb0_rd", t);

    xact(mk(1'b1, 32'h8009_0020, 32'd5, 4'd0, 2'd2, 4'hF), "amo_init", t);
    xact(mk(1'b0, 32'h8009_0020, 32'd3, AMO_ADD, 2'd2, 4'hF), "amo_add", t);
    xact(mk(1'b0, 32'h8009_0020, 32'h0, 4'd0, 2'd2, 4'hF), "amo_add_rd", t);
    xact(mk(1'b0, 32'h8009_0020, 32'hFFFF_FFFF, AMO_MINU, 2'd2, 4'hF), "amo_minu", t);
    xact(mk(1'b0, 32'h8009_0020, 32'h0, 4'd0, 2'd2, 4'hF), "amo_minu_rd", t);

    xact(mk(1'b0, 32'h8008_FFFC, 32'h0, 4'd0, 2'd2, 4'hF), "err_below", t);
    xact(mk(1'b0, 32'h8009_0002, 32'h0, 4'd0, 2'd2, 4'hF), "err_misalign", t);
    xact(mk(1'b0, 32'h8009_0020, 32'h7, 4'd10, 2'd2, 4'hF), "err_amo10", t);
    xact(mk(1'b0, 32'h8009_0020, 32'h7, AMO_ADD, 2'd0, 4'hF), "err_amo_size", t);
    xact(mk(1'b0, BASE + SIZE, 32'h0, 4'd0, 2'd2, 4'hF), "err_above", t);
    xact(mk(1'b0, 32'h8009_0020, 32'h0, 4'd0, 2'd2, 4'hF), "err_unchanged", t);

    // Four loads with req held high throughout: acks two cycles apart.
    xact(mk(1'b0, 32'h8009_0000, 32'h0, 4'd0, 2'd2, 4'hF), "b2b0", c0);
    xact(mk(1'b0, 32'h8009_0004, 32'h0, 4'd0, 2'd2, 4'hF), "b2b1", c1);
    xact(mk(1'b0, 32'h8009_0010, 32'h0, 4'd0, 2'd2, 4'hF), "b2b2", c2);
    xact(mk(1'b0, 32'h8009_0020, 32'h0, 4'd0, 2'd2, 4'hF), "b2b3", c3);
    check("b2b_gap1", 32'(c1 - c0), 32'd2);
    check("b2b_gap2", 32'(c2 - c1), 32'd2);
    check("b2b_gap3", 32'(c3 - c2), 32'd2);

    // Reset while the atomic sits in its read phase: no ack and memory untouched.
    idle(1);
    req = mk(1'b0, 32'h8009_0020, 32'h1234_5678, AMO_SWAP, 2'd2, 4'hF);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_amo_ack", 32'(ack.ack), 32'h0);
    check("rst_amo_rdata", ack.rdata, 32'h0);
    @(posedge clk);
    #1;
    req = '0;
    rst = 1'b0;
    idle(3);
    xact(mk(1'b0, 32'h8009_0020, 32'h0, 4'd0, 2'd2, 4'hF), "rst_amo_rd", t);

    // Randomized mix of loads, stores, atomics and illegal requests.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] addr;
      case ($urandom % 8)
        0: addr = BASE - 32'(4 * ($urandom % 4 + 1));
        1: addr = BASE + SIZE + 32'($urandom % 16);
        2: addr = BASE + SIZE - 32'd4 + 32'($urandom % 4);
        default: addr = BASE + 32'($urandom % 64);
      endcase
      r = mk(1'($urandom), addr, $urandom, 4'd0, 2'($urandom), 4'($urandom));
      if ($urandom % 2 == 0) begin
        r.amo = 4'($urandom);
        if (r.amo != 4'd0 && ($urandom % 4) != 0) begin
          r.size = 2'd2;
          r.addr = {r.addr[31:2], 2'b00};
        end
      end
      if ($urandom % 4 == 0) idle(1 + int'($urandom % 3));
      xact(r, "rand", t);
    end

    idle(4);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_tcm_responder.md
LSU_TCM_RESPONDER -- requirements
Module: lsu_tcm_responder

Interface
REQ-001 The block SHALL have parameter BASE, default 32'h8009_0000 (DTCM_BASE), meaning the first byte address served.
REQ-002 The block SHALL have parameter SIZE, default 32'h0001_0000 (DTCM_SIZE), meaning the region size in bytes, a power of two and at least 4.
REQ-003 The block SHALL have port clk_i, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port lsu_req_i, input, lsu_req_t: req, we, addr, wdata, amo, size, strb from the initiator.
REQ-006 The block SHALL have port lsu_ack_o, output, lsu_ack_t: ack, error, rdata to the initiator.

Function
REQ-007 The initiator SHALL hold lsu_req_i stable from req=1 until the cycle ack=1; ack SHALL be a single-cycle pulse.
REQ-008 The block SHALL sample req only in IDLE; req seen in IDLE on the cycle after an ack is a new, back-to-back request.
REQ-009 State machine: IDLE, RESP, AMO_RD, AMO_WR; transitions occur on the rising edge of clk_i.
REQ-010 IDLE with req=1 and error condition: go to RESP with the error flag set; memory is not accessed.
REQ-011 IDLE with req=1, valid, amo=0: issue an SRAM read (we=0) or byte-masked write (we=1, strb) and go to RESP.
REQ-012 IDLE with req=1, valid, amo!=0: issue an SRAM read and go to AMO_RD.
REQ-013 RESP: ack=1. rdata is the SRAM word for a valid read and 0 for writes and errors. error reflects the latched flag. Next state is IDLE.
REQ-014 AMO_RD: latch the old word, compute new=f(old, wdata), issue a full-word write and go to AMO_WR.
REQ-015 AMO_WR: ack=1, rdata = old word, error=0. Next state is IDLE.
REQ-016 Latency from the sampling edge to ack: 1 cycle for load, store and error; 2 cycles for AMO.
REQ-017 Error condition: addr outside [BASE, BASE+SIZE-1], or size=3, or misaligned access, or amo is an undefined code, or amo!=0 with size!=2.
REQ-018 Misaligned means size=1 with addr[0]=1, or size=2 with addr[1:0]!=0.
REQ-019 The word index SHALL be (addr-BASE)[log2(SIZE)-1:2]; rdata always returns the full aligned word.
REQ-020 AMO codes: 1 SWAP, 2 ADD (mod 2^32), 3 XOR, 4 AND, 5 OR, 6 MIN signed, 7 MAX signed, 8 MINU, 9 MAXU; codes 10-15 are errors.
REQ-021 Writes SHALL modify only the byte lanes whose strb bit is 1; strb=0000 on a store is a valid no-op write that is still acked.

Reset
REQ-022 On rst_i=1, regardless of clk_i: state=IDLE, ack=0, error=0, rdata=0, and the latched old word and error flag are cleared.
REQ-023 Reset mid-transaction SHALL drop the pending ack.
REQ-024 Reset asserted in AMO_RD before the clock edge SHALL leave memory unchanged.
REQ-025 SRAM contents SHALL NOT be reset.

Structure
REQ-026 The AMO code localparams (AMO_NONE..AMO_MAXU) SHALL live in SOPHON_PKG next to lsu_req_t and lsu_ack_t.
REQ-027 The state enum SHALL be local to the module.
REQ-028 The storage SHALL be one sub-module, tcm_sram: SIZE/4 x 32-bit words, one port, 1-cycle read latency, per-byte write enable, no reset.

Verification
REQ-029 Word write 0x8009_0010 with wdata 0xDEADBEEF, strb 1111, then a read of the same address: each ack comes 1 cycle after sampling; the read returns rdata 0xDEADBEEF, error 0.
REQ-030 Byte store size=0 to 0x8009_0011 with wdata 0x0000_AB00, strb 0010, then a word read: rdata 0xDEADABEF.
REQ-031 AMO ADD at a word holding 5 with wdata 3: ack after 2 cycles with rdata 5; a following read returns 8. Then AMO MINU with wdata 0xFFFF_FFFF: rdata 8, word stays 8.
REQ-032 Read at 0x8008_FFFC, and a word read at 0x8009_0002: ack 1 cycle later with error 1, rdata 0, memory unchanged. Also amo=10, and AMO with size=0: error 1.
REQ-033 req held high for 4 back-to-back loads: exactly 4 acks, spaced every 2 cycles, with correct data for each.
REQ-034 rst_i pulsed during AMO_RD: no ack, the target word keeps its old value, state is IDLE.
